// File: rtl/zigzag_quantizer_pkg.sv
// Shared tables and encodings for the zigzag quantizer: scan order, JPEG luminance
// quantizer table, and its 17-bit reciprocals stored in zigzag order.
package zigzag_quantizer_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam int RW = 17;

  // Zigzag index k -> buffer address {u, v} (row-major, u = row, v = column)
  localparam logic [5:0] ZZ_ADDR [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  // Luminance quantizer table, row-major
  localparam logic [7:0] Q_LUMA [64] = '{
    16,  11,  10,  16,  24,  40,  51,  61,
    12,  12,  14,  19,  26,  58,  60,  55,
    14,  13,  16,  24,  40,  57,  69,  56,
    14,  17,  22,  29,  51,  87,  80,  62,
    18,  22,  37,  56,  68, 109, 103,  77,
    24,  35,  55,  64,  81, 104, 113,  92,
    49,  64,  78,  87, 103, 121, 120, 101,
    72,  92,  95,  98, 112, 100, 103,  99
  };

  // round(65536 / Q_LUMA[ZZ_ADDR[k]]), indexed by zigzag position k
  localparam logic [RW-1:0] R_TAB [64] = '{
    4096, 5958, 5461, 4681, 5461, 6554, 4096, 4681,
    5041, 4681, 3641, 3855, 4096, 3449, 2731, 1638,
    2521, 2731, 2979, 2979, 2731, 1337, 1872, 1771,
    2260, 1638, 1130, 1285, 1074, 1092, 1150, 1285,
    1170, 1192, 1024,  910,  712,  840, 1024,  964,
     753,  950, 1192, 1170,  819,  601,  809,  753,
     690,  669,  636,  630,  636, 1057,  851,  580,
     542,  585,  655,  546,  712,  649,  636,  662
  };

endpackage

// File: rtl/quant_mul.sv
// Combinational quantizer: coefficient times reciprocal, round-half-up,
// arithmetic shift, then saturate to the output width.
module quant_mul
  import zigzag_quantizer_pkg::*;
#(
  parameter int CW    = 19,
  parameter int QW    = 12,
  parameter int SHIFT = 0
) (
  input  logic signed [CW-1:0] coef,
  input  logic        [RW-1:0] recip,
  output logic signed [QW-1:0] q
);

  localparam int PW = CW + RW;
  localparam logic signed [PW-1:0] HALF = PW'(1) << (15 + SHIFT);
  localparam logic signed [PW-1:0] QMAX = PW'((1 << (QW - 1)) - 1);
  localparam logic signed [PW-1:0] QMIN = -QMAX - PW'(1);

  function automatic logic signed [PW-1:0] rnd_shift(input logic signed [PW-1:0] p);
    rnd_shift = (p + HALF) >>> (16 + SHIFT);
  endfunction

  function automatic logic signed [QW-1:0] sat(input logic signed [PW-1:0] v);
    logic signed [QW-1:0] r;
    if (v > QMAX)      r = QMAX[QW-1:0];
    else if (v < QMIN) r = QMIN[QW-1:0];
    else               r = v[QW-1:0];
    sat = r;
  endfunction

  logic signed [PW-1:0] coef_x;
  logic signed [PW-1:0] rcp_x;
  logic signed [PW-1:0] prod;

  assign coef_x = PW'(coef);
  assign rcp_x  = PW'(recip);
  assign prod   = coef_x * rcp_x;
  assign q      = sat(rnd_shift(prod));

endmodule

// File: rtl/zigzag_quantizer.sv
// Buffers an 8x8 coefficient block column by column, then streams it out in
// zigzag order through a quantizer with valid/ready backpressure.
module zigzag_quantizer
  import zigzag_quantizer_pkg::*;
#(
  parameter int N     = 8,
  parameter int CW    = 4 * N - 13,
  parameter int QW    = 12,
  parameter int SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [CW-1:0] in_c0,
  input  logic signed [CW-1:0] in_c1,
  input  logic signed [CW-1:0] in_c2,
  input  logic signed [CW-1:0] in_c3,
  input  logic signed [CW-1:0] in_c4,
  input  logic signed [CW-1:0] in_c5,
  input  logic signed [CW-1:0] in_c6,
  input  logic signed [CW-1:0] in_c7,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [QW-1:0] out_q,
  output logic [5:0]           out_idx,
  output logic                 out_last
);

  state_e state, state_nxt;
  logic [2:0] col;
  logic [5:0] k;
  logic       iss_done;
  logic       rdy;
  logic       accept, out_en, out_hs, issue;

  logic signed [CW-1:0] buf_mem [64];
  logic signed [CW-1:0] cols [8];

  logic signed [CW-1:0] coef_p0;
  logic [5:0]           idx_p0;
  logic                 vld_p0;
  logic signed [QW-1:0] q_p1;

  assign cols     = '{in_c0, in_c1, in_c2, in_c3, in_c4, in_c5, in_c6, in_c7};
  assign in_ready = rdy;
  assign accept   = in_valid && rdy;
  assign out_en   = !out_valid || out_ready;
  assign out_hs   = out_valid && out_ready;
  // k is the read address; it runs one entry ahead of out_idx because of stage p0
  assign issue    = (state == DRAIN) && !iss_done && (!vld_p0 || out_en);

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (accept && col == 3'd7) state_nxt = DRAIN;
      DRAIN:   if (out_hs && out_last)    state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // in_ready is registered so it stays low throughout reset and rises one clock after release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FILL;
      rdy      <= 1'b0;
      col      <= '0;
      k        <= '0;
      iss_done <= 1'b0;
    end else begin
      state <= state_nxt;
      rdy   <= (state_nxt == FILL);
      if (accept) col <= col + 3'd1;
      if (issue) begin
        k <= k + 6'd1;
        if (k == 6'd63) iss_done <= 1'b1;
      end
      if (state == DRAIN && state_nxt == FILL) begin
        k        <= '0;
        iss_done <= 1'b0;
        col      <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int u = 0; u < 8; u++) buf_mem[{3'(u), col}] <= cols[u];
    end
  end

  // Stage p0: zigzag read of the buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      vld_p0 <= 1'b0;
    else if (issue)  vld_p0 <= 1'b1;
    else if (out_en) vld_p0 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      coef_p0 <= buf_mem[ZZ_ADDR[k]];
      idx_p0  <= k;
    end
  end

  quant_mul #(
    .CW   (CW),
    .QW   (QW),
    .SHIFT(SHIFT)
  ) u_quant_mul (
    .coef (coef_p0),
    .recip(R_TAB[idx_p0]),
    .q    (q_p1)
  );

  // Stage p1: output register, held while stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else if (out_en) begin
      out_valid <= vld_p0;
      out_last  <= vld_p0 && (idx_p0 == 6'd63);
      if (vld_p0) begin
        out_q   <= q_p1;
        out_idx <= idx_p0;
      end
    end
  end

endmodule

// File: tb/tb_zigzag_quantizer.sv
// Scoreboard bench for zigzag_quantizer: blocks are driven column by column and
// the expected zigzag/quantized stream is queued and compared at each output handshake.
module tb_zigzag_quantizer;

  localparam int N     = 8;
  localparam int CW    = 4 * N - 13;
  localparam int QW    = 12;
  localparam int SHIFT = 0;
  localparam int QMAXV = (1 << (QW - 1)) - 1;
  localparam int QMINV = -(1 << (QW - 1));

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [CW-1:0] in_c0, in_c1, in_c2, in_c3, in_c4, in_c5, in_c6, in_c7;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [QW-1:0] out_q;
  logic [5:0]           out_idx;
  logic                 out_last;

  always #5 clk = ~clk;

  zigzag_quantizer #(.N(N), .CW(CW), .QW(QW), .SHIFT(SHIFT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_c0(in_c0), .in_c1(in_c1), .in_c2(in_c2), .in_c3(in_c3),
    .in_c4(in_c4), .in_c5(in_c5), .in_c6(in_c6), .in_c7(in_c7),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q),
    .out_idx(out_idx), .out_last(out_last)
  );

  typedef struct {
    int q;
    int idx;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cur [64];
  int   zr [64];
  int   zc [64];
  int   qtab [64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,   12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,   14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68, 109, 103, 77, 24, 35, 55, 64, 81, 104, 113, 92,
    49, 64, 78, 87, 103, 121, 120, 101, 72, 92, 95, 98, 112, 100, 103, 99
  };
  bit   rnd_ready = 1'b0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_q(int c, int r);
    longint p;
    p = (longint'(c) * longint'(r) + (64'sd1 <<< (15 + SHIFT))) >>> (16 + SHIFT);
    if (p > QMAXV) return QMAXV;
    if (p < QMINV) return QMINV;
    return int'(p);
  endfunction

  task automatic build_zz();
    int r = 0, c = 0;
    for (int i = 0; i < 64; i++) begin
      zr[i] = r;
      zc[i] = c;
      if (((r + c) % 2) == 0) begin
        if (c == 7) r++;
        else if (r == 0) c++;
        else begin r--; c++; end
      end else begin
        if (r == 7) c++;
        else if (c == 0) r++;
        else begin r++; c--; end
      end
    end
  endtask

  task automatic push_block();
    for (int i = 0; i < 64; i++) begin
      int n, r;
      exp_t e;
      n = zr[i] * 8 + zc[i];
      r = (65536 + qtab[n] / 2) / qtab[n];
      e.q = model_q(cur[n], r);
      e.idx = i;
      sbq.push_back(e);
    end
  endtask

  task automatic fill_random(input int mag);
    for (int i = 0; i < 64; i++) cur[i] = int'($urandom_range(0, 2 * mag)) - mag;
  endtask

  task automatic fill_zero();
    for (int i = 0; i < 64; i++) cur[i] = 0;
  endtask

  task automatic send_block(input bit push, input bit keep_valid, input int nbeats);
    if (push) push_block();
    for (int b = 0; b < nbeats; b++) begin
      bit acc = 1'b0;
      int g = 0;
      in_c0 = CW'(cur[0 * 8 + b]); in_c1 = CW'(cur[1 * 8 + b]);
      in_c2 = CW'(cur[2 * 8 + b]); in_c3 = CW'(cur[3 * 8 + b]);
      in_c4 = CW'(cur[4 * 8 + b]); in_c5 = CW'(cur[5 * 8 + b]);
      in_c6 = CW'(cur[6 * 8 + b]); in_c7 = CW'(cur[7 * 8 + b]);
      in_valid = 1'b1;
      while (!acc && g < 300) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        g++;
      end
      if (!acc) chk("beat_accept_timeout", 0, 1);
    end
    if (keep_valid) begin
      in_c0 = 19'sd1111; in_c1 = 19'sd2222; in_c2 = 19'sd3333; in_c3 = 19'sd4444;
      in_c4 = 19'sd5555; in_c5 = 19'sd6666; in_c6 = 19'sd7777; in_c7 = 19'sd8888;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((sbq.size() != 0 || out_valid) && g < 1500) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("drain_left", sbq.size(), 0);
  endtask

  // Output monitor: sampled on the falling edge, handshakes land on the next rising edge
  bit                   stall_prev = 1'b0;
  logic signed [QW-1:0] hq;
  logic [5:0]           hidx;

  always @(negedge clk) begin
    if (reset) begin
      if (out_valid) chk("in_ready_during_output", in_ready, 0);
      if (out_valid && !out_ready) begin
        if (stall_prev) begin
          chk("stall_q", out_q, hq);
          chk("stall_idx", out_idx, hidx);
        end
        hq = out_q;
        hidx = out_idx;
        stall_prev = 1'b1;
      end else begin
        stall_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_out_idx", out_idx, -1);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk($sformatf("q[%0d]", e.idx), out_q, e.q);
          chk($sformatf("idx[%0d]", e.idx), out_idx, e.idx);
          chk($sformatf("last[%0d]", e.idx), out_last, (e.idx == 63) ? 1 : 0);
        end
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g;
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_c0 = '0; in_c1 = '0; in_c2 = '0; in_c3 = '0;
    in_c4 = '0; in_c5 = '0; in_c6 = '0; in_c7 = '0;
    build_zz();

    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_q", out_q, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("in_ready_before_first_clk", in_ready, 0);
    @(posedge clk);
    #1;
    chk("in_ready_after_release", in_ready, 1);

    // All-zero block: latency, consecutive stream, return to FILL
    fill_zero();
    send_block(1'b1, 1'b0, 8);
    chk("in_ready_after_8th", in_ready, 0);
    chk("lat_edge0_valid", out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_edge1_valid", out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_edge2_valid", out_valid, 1);
    chk("first_idx", out_idx, 0);
    repeat (63) @(posedge clk);
    #1;
    chk("idx63_valid", out_valid, 1);
    chk("idx63_last", out_last, 1);
    chk("idx63_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    chk("fill_in_ready", in_ready, 1);
    chk("fill_out_valid", out_valid, 0);
    chk("zero_block_left", sbq.size(), 0);

    // DC and first AC term
    fill_zero();
    cur[0] = 1600;
    cur[1] = -330;
    send_block(1'b1, 1'b0, 8);
    wait_drain();

    // Saturation at both ends
    fill_zero();
    cur[0] = 262143;
    cur[63] = -262144;
    send_block(1'b1, 1'b0, 8);
    wait_drain();

    // Five-cycle stall at idx 10
    fill_random(20000);
    send_block(1'b1, 1'b0, 8);
    g = 0;
    while (!(out_valid && out_idx == 6'd10) && g < 300) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("reach_idx10", out_idx, 10);
    out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("stall_end_idx", out_idx, 10);
    chk("stall_end_valid", out_valid, 1);
    out_ready = 1'b1;
    wait_drain();

    // Random backpressure
    rnd_ready = 1'b1;
    fill_random(20000);
    send_block(1'b1, 1'b0, 8);
    wait_drain();
    rnd_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;

    // Reset after the 4th beat, then a clean block
    fill_random(20000);
    send_block(1'b0, 1'b0, 4);
    #3;
    reset = 1'b0;
    #1;
    chk("midfill_rst_in_ready", in_ready, 0);
    chk("midfill_rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midfill_release_in_ready", in_ready, 1);
    fill_random(20000);
    send_block(1'b1, 1'b0, 8);
    wait_drain();

    // Reset while a block is draining and stalled
    out_ready = 1'b0;
    fill_random(20000);
    send_block(1'b0, 1'b0, 8);
    g = 0;
    while (!out_valid && g < 50) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("middrain_valid_seen", out_valid, 1);
    #3;
    reset = 1'b0;
    #1;
    chk("middrain_rst_valid", out_valid, 0);
    chk("middrain_rst_q", out_q, 0);
    chk("middrain_rst_idx", out_idx, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("middrain_no_stale", out_valid, 0);
    chk("middrain_in_ready", in_ready, 1);

    // Back-to-back blocks with in_valid held high through DRAIN
    fill_random(20000);
    send_block(1'b1, 1'b1, 8);
    chk("b2b_in_ready_drain", in_ready, 0);
    fill_random(20000);
    send_block(1'b1, 1'b0, 8);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/zigzag_quantizer.md
ZIGZAG_QUANTIZER -- requirements
Module: zigzag_quantizer

Interface
REQ-001 Parameter N, default 8: pixel width of the DCT datapath.
REQ-002 Parameter CW, default 4*N-13 (19): signed width of each 2-D DCT coefficient.
REQ-003 Parameter QW, default 12: signed width of each quantized output.
REQ-004 Parameter SHIFT, default 0: extra right-shift applied after quantization to remove fixed DCT scaling.
REQ-005 The ports SHALL be, in this order:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  reset, asynchronous and active-low.
- in_valid  in  1  the current beat carries one column of a coefficient block.
- in_ready  out  1  the block can accept a column.
- in_c0..in_c7  in  CW each  signed coefficients coef[u][v] for u = 0..7, where v = column index of the beat.
- out_valid  out  1  out_q holds a quantized coefficient.
- out_ready  in  1  downstream accepts out_q.
- out_q  out  QW  signed quantized coefficient, in zigzag order.
- out_idx  out  6  zigzag index 0..63 of out_q.
- out_last  out  1  out_q is zigzag index 63.

Function
REQ-006 The block SHALL have states FILL and DRAIN; a 64-entry coefficient buffer SHALL hold coef[u][v].
- In FILL, in_ready = 1.
- A beat is accepted when in_valid and in_ready are both 1.
- Accepted beat b (b = 0..7, counted from 0 by a 3-bit column counter) SHALL write in_cu to buf[u][b].
REQ-007 The cycle after the 8th accepted beat, the state SHALL become DRAIN and in_ready SHALL be 0; in_valid in DRAIN SHALL be ignored.
REQ-008 DRAIN sequencing:
- A 6-bit zigzag counter k SHALL address buf via the standard JPEG zigzag table: k=0 (0,0), 1 (0,1), 2 (1,0), 3 (2,0), 4 (1,1), 5 (0,2) ... 63 (7,7), where (u,v) = (row, column).
- k advances on each output handshake.
REQ-009 Quantization arithmetic:
- q = (coef × R[k] + 2^(15+SHIFT)) >>> (16+SHIFT), arithmetic shift.
- R[k] = round(65536 / Q[zigzag(k)]), where Q is the standard JPEG luminance table.
- The product SHALL be CW+17 bits signed.
REQ-010 q SHALL saturate to [-2^(QW-1), 2^(QW-1)-1]: -2048..2047 for QW = 12.
REQ-011 The output register (out_q, out_idx, out_last, out_valid) SHALL load whenever out_valid = 0 or out_ready = 1. out_q, out_idx and out_last SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-012 The first out_valid SHALL rise 2 cycles after the clock edge accepting the 8th beat; with out_ready held at 1, 64 outputs SHALL follow on consecutive cycles.
REQ-013 After the handshake of out_last, the state SHALL return to FILL with in_ready = 1 on the next cycle and the column counter at 0. The final output and the next block's first beat SHALL NOT overlap.
REQ-014 No coefficient SHALL be dropped or duplicated under any out_ready pattern.

Reset
REQ-015 While reset = 0, the following SHALL be forced immediately, independent of clk:
- state = FILL, column counter = 0, k = 0.
- in_ready = 0 while reset is asserted and 1 from the first clock after release.
- out_valid = 0, out_q = 0, out_idx = 0, out_last = 0.
REQ-016 Buffer contents need not reset. Reset mid-FILL or mid-DRAIN SHALL discard the partial block, and no stale output SHALL appear after release.

Structure
REQ-017 A shared package SHALL hold:
- the zigzag-to-(u,v) table (64 entries),
- the luminance Q table,
- the 17-bit reciprocal table R,
- state encodings.
REQ-018 One sub-module, quant_mul, SHALL implement the multiply, round, shift and saturate path combinationally; zigzag_quantizer SHALL instantiate it once.

Verification
REQ-019 All-zero block, out_ready = 1 -> 64 outputs of 0, out_idx 0..63, out_last only at idx 63, in_ready back to 1 the next cycle.
REQ-020 Block with coef[0][0] = 1600 and coef[0][1] = -330, all others 0 -> idx0 = 100, idx1 = -30, all others 0.
REQ-021 coef[0][0] = 262143 and coef[7][7] = -262144 -> idx0 = 2047, idx63 = -2048 (saturated).
REQ-022 out_ready held low for 5 cycles at idx 10 -> out_q and out_idx stable for those cycles; the full 64-output sequence is intact.
REQ-023 reset pulsed low after the 4th beat, then a full block applied -> only that block's 64 outputs appear, correct values.
REQ-024 Two blocks back-to-back with in_valid held at 1 -> no beat is accepted during DRAIN; the second block is output in full after the first block's out_last.
